// File: rtl/cache_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arbiter_if
//  Description : Physical-memory port bundle shared by cache miss ports,
//                the arbiter and physical memory. The master issues
//                line-read/line-write requests; the slave returns data and
//                a one-cycle completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) ();
    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_address;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic [LINE_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport master (
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp
    );

    modport slave (
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp
    );
endinterface
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_arbiter
//  Description : Round-robin arbiter serializing whole cache-line
//                transactions from the icache and dcache miss ports onto a
//                single physical-memory port. Address and write line are
//                captured at grant and held for the whole transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic            clk,
    input  logic            rst,
    cache_arbiter_if.slave  icache,
    cache_arbiter_if.slave  dcache,
    cache_arbiter_if.master pmem
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last_grant;   // 0 = icache, 1 = dcache
    logic                  r_op_is_write;
    logic [ADDR_WIDTH-1:0] r_addr_q;
    logic [LINE_WIDTH-1:0] r_wdata_q;

    logic                  w_i_req;
    logic                  w_d_req;
    logic                  w_grant;
    logic                  w_grant_d;
    logic                  w_pmem_read;
    logic                  w_pmem_write;
    logic                  w_i_resp;
    logic                  w_d_resp;

    assign w_i_req = icache.pmem_read | icache.pmem_write;
    assign w_d_req = dcache.pmem_read | dcache.pmem_write;

    // Next-state arbitration and per-state outputs
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_d    = 1'b0;
        w_pmem_read  = 1'b0;
        w_pmem_write = 1'b0;
        w_i_resp     = 1'b0;
        w_d_resp     = 1'b0;
        case (r_state)
            IDLE: begin
                // On a tie the client that was not served last wins
                if (w_i_req && w_d_req) begin
                    w_grant   = 1'b1;
                    w_grant_d = ~r_last_grant;
                end else if (w_i_req) begin
                    w_grant   = 1'b1;
                end else if (w_d_req) begin
                    w_grant   = 1'b1;
                    w_grant_d = 1'b1;
                end
                if (w_grant) begin
                    w_next_state = w_grant_d ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                w_pmem_read  = ~r_op_is_write;
                w_pmem_write = r_op_is_write;
                w_i_resp     = pmem.pmem_resp;
                if (pmem.pmem_resp) begin
                    w_next_state = IDLE;
                end
            end
            SERVE_D: begin
                w_pmem_read  = ~r_op_is_write;
                w_pmem_write = r_op_is_write;
                w_d_resp     = pmem.pmem_resp;
                if (pmem.pmem_resp) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the granted client's transaction so memory sees stable inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant  <= 1'b1;
            r_op_is_write <= 1'b0;
            r_addr_q      <= '0;
            r_wdata_q     <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_grant_d;
            if (w_grant_d) begin
                // Read and write both asserted is treated as a write
                r_op_is_write <= dcache.pmem_write;
                r_addr_q      <= dcache.pmem_address;
                r_wdata_q     <= dcache.pmem_wdata;
            end else begin
                r_op_is_write <= icache.pmem_write;
                r_addr_q      <= icache.pmem_address;
                r_wdata_q     <= icache.pmem_wdata;
            end
        end
    end

    assign pmem.pmem_read    = w_pmem_read;
    assign pmem.pmem_write   = w_pmem_write;
    assign pmem.pmem_address = r_addr_q;
    assign pmem.pmem_wdata   = r_wdata_q;

    // Read data goes to both clients; only the served one sees resp
    assign icache.pmem_rdata = pmem.pmem_rdata;
    assign dcache.pmem_rdata = pmem.pmem_rdata;
    assign icache.pmem_resp  = w_i_resp;
    assign dcache.pmem_resp  = w_d_resp;

endmodule
`default_nettype wire

// File: doc/cache_arbiter.md
# cache_arbiter

Two-client arbiter between the instruction cache and data cache miss ports and the single physical-memory port. It sits directly downstream of both caches' `pmem_*` interfaces and is transparent to them: each cache's control FSM holds `pmem_read`/`pmem_write` until it sees `pmem_resp`. The arbiter serializes whole cache-line transactions, read fill or dirty write-back, with round-robin fairness. Address and write data are registered at grant so that physical memory sees stable inputs for the whole transaction.

## Interface
- `ADDR_WIDTH`, default 16: byte address width (lc3b_word).
- `LINE_WIDTH`, default 128: cache line width (lc3b_cacheline).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `i_pmem_read` in 1: icache line-read request.
- `i_pmem_write` in 1: icache line-write request.
- `i_pmem_address` in ADDR_WIDTH: icache line address.
- `i_pmem_wdata` in LINE_WIDTH: icache write line.
- `i_pmem_rdata` out LINE_WIDTH: read line returned to icache.
- `i_pmem_resp` out 1: icache transaction complete.
- `d_pmem_read`, `d_pmem_write`, `d_pmem_address`, `d_pmem_wdata`, `d_pmem_rdata`, `d_pmem_resp`: the same ports for the dcache.
- `pmem_read` out 1: read request to physical memory.
- `pmem_write` out 1: write request to physical memory.
- `pmem_address` out ADDR_WIDTH: registered address.
- `pmem_wdata` out LINE_WIDTH: registered write line.
- `pmem_rdata` in LINE_WIDTH: line from physical memory.
- `pmem_resp` in 1: physical memory done, one-cycle pulse.

## Operation
- States: `IDLE`, `SERVE_I`, `SERVE_D`. Additional registers:
  - `last_grant`: 0 = I, 1 = D.
  - `op_is_write`
  - `addr_q`
  - `wdata_q`
- Client request: `x_req = x_pmem_read | x_pmem_write`. If a client asserts both read and write, the operation is a write.
- IDLE arbitration:
  - No request: stay in IDLE.
  - Only I requests: go to `SERVE_I`.
  - Only D requests: go to `SERVE_D`.
  - Both request: grant the client that is not `last_grant`.
  - On the grant edge, capture `addr_q`, `wdata_q` and `op_is_write` from the granted client, and set `last_grant` to the granted client.
- SERVE_x:
  - `pmem_read = ~op_is_write` and `pmem_write = op_is_write`, held every cycle until and including the cycle in which `pmem_resp = 1`.
  - When `pmem_resp = 1`: `x_pmem_resp = 1` in the same cycle (combinational), and the next state is IDLE.
  - Changes on the client's inputs during SERVE are ignored. A client dropping its request mid-transaction does not abort the transaction.
- Data and response routing:
  - `i_pmem_rdata = d_pmem_rdata = pmem_rdata`, a combinational passthrough to both clients.
  - `i_pmem_resp = pmem_resp & (state == SERVE_I)`.
  - `d_pmem_resp = pmem_resp & (state == SERVE_D)`.
  - A `pmem_resp` received in IDLE is ignored; neither client sees it.
- The non-granted client's request stays pending. It is granted from IDLE after the current transaction, and round-robin guarantees it is served next.
- A write-back followed by a fill from the same cache is two separate transactions. If the other cache is waiting, it is served between them.

## Timing
- Reset values:
  - `state = IDLE`, `last_grant = 1` (so the first tie goes to I), `op_is_write = 0`, `addr_q = 0`, `wdata_q = 0`.
  - All outputs `pmem_read`, `pmem_write`, `i_pmem_resp`, `d_pmem_resp` = 0; `pmem_address = 0`; `pmem_wdata = 0`.
- Request latency: a request seen in IDLE at edge N puts `pmem_read`/`pmem_write` high from cycle N+1. Arbitration costs exactly one bubble cycle per transaction.
- Completion latency: `pmem_resp` in cycle M produces `x_pmem_resp` in cycle M. `pmem_read`/`pmem_write` are low in cycle M+1 (IDLE). The earliest next grant is seen at edge M+1, with new requests asserted in cycle M+2.
- `pmem_address` and `pmem_wdata` are driven from registers and do not change during SERVE.
- Reset asserted mid-transaction:
  - Next cycle is IDLE with all strobes low.
  - No `x_pmem_resp` is generated after reset.
  - The memory model and both caches must be reset together.

## Test plan
- Single icache read: addr 0x1230 held from reset release; memory responds after 5 cycles with 0xDEADBEEF_... Required:
  - `pmem_read` high for exactly 5 cycles starting 1 cycle after the request.
  - `pmem_address = 0x1230`.
  - `i_pmem_resp` pulses 1 cycle; `i_pmem_rdata` matches; `d_pmem_resp` stays 0.
- Simultaneous requests after reset: I reads 0x0040, D writes 0x8000. Required:
  - I is served first; D then gets `pmem_write` with `pmem_address = 0x8000` and the registered wdata.
  - Each client receives exactly one resp.
- Round-robin: D issues back-to-back requests while I requests continuously. Required: grants alternate I, D, I, D; no client is served twice in a row while the other waits.
- Dcache write-back then fill (0x8000 write, then 0x8000 read) while icache reads 0x0100. Required: order is D-write, I-read, D-read; memory contents at 0x8000 are correct on the final read.
- Input instability: change `d_pmem_address` and `d_pmem_wdata` every cycle during `SERVE_D`. Required: `pmem_address` and `pmem_wdata` hold their grant-edge values.
- Reset in the 3rd cycle of a D read, plus a spurious `pmem_resp` in IDLE. Required:
  - Strobes go low the next cycle.
  - No client resp for either the aborted read or the spurious pulse.
  - A subsequent I read completes normally.
